// File: rtl/am_mod_pkg.sv
// Shared constants, quadrant type and arithmetic helpers for the AM modulator.
// The sine table is generated at elaboration time from quarter_sine().
package am_mod_pkg;

  localparam int unsigned PHASE_W           = 32;
  localparam int unsigned LUT_AW            = 8;
  localparam int unsigned AUD_W             = 18;
  localparam int unsigned DAC_W             = 8;
  localparam int unsigned SINE_W            = 16;
  localparam int unsigned PROD_W            = AUD_W + SINE_W;
  localparam int          ENV_ONE           = 2**16;
  localparam int unsigned SHIFT             = 25;
  localparam int          DAC_MAX           = 2**(DAC_W-1) - 1;
  localparam int unsigned DEFAULT_PHASE_INC = 343597384;
  localparam int unsigned DEFAULT_INTERP    = 125;

  typedef enum logic [1:0] {
    QUAD_0 = 2'd0,
    QUAD_1 = 2'd1,
    QUAD_2 = 2'd2,
    QUAD_3 = 2'd3
  } quadrant_t;

  // Half-bin offset keeps the table symmetric, so mirroring a quadrant is a plain bit flip.
  function automatic int quarter_sine(input int unsigned idx, input int unsigned aw);
    real ang;
    ang = 1.5707963267948966 * (real'(idx) + 0.5) / real'(2**aw);
    return $rtoi(real'(2**(SINE_W-1) - 1) * $sin(ang) + 0.5);
  endfunction

  function automatic logic signed [DAC_W-1:0] sat_dac(input logic signed [PROD_W-1:0] p);
    logic signed [PROD_W-1:0] sh;
    logic signed [DAC_W-1:0]  res;
    sh = p >>> SHIFT;
    if (sh > PROD_W'(DAC_MAX)) begin
      res = DAC_W'(DAC_MAX);
    end else if (sh < PROD_W'(-DAC_MAX)) begin
      res = DAC_W'(-DAC_MAX);
    end else begin
      res = DAC_W'(sh);
    end
    return res;
  endfunction

endpackage

// File: rtl/am_modulator_rom.sv
// Quarter-wave sine ROM with a registered one-cycle read; unsigned amplitude.
module quarter_sine_rom #(
  parameter int unsigned LUT_AW = am_mod_pkg::LUT_AW,
  parameter int unsigned SINE_W = am_mod_pkg::SINE_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [LUT_AW-1:0] addr,
  output logic [SINE_W-1:0] data
);
  import am_mod_pkg::*;

  logic [SINE_W-1:0] rom [2**LUT_AW];

  for (genvar i = 0; i < 2**LUT_AW; i++) begin : g_rom
    localparam logic [SINE_W-1:0] VAL = SINE_W'(quarter_sine(i, LUT_AW));
    assign rom[i] = VAL;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data <= '0;
    end else begin
      data <= rom[addr];
    end
  end

endmodule

// File: rtl/am_modulator.sv
// Full-carrier AM modulator: zero-order-held audio forms 0.5 + 0.5*m*audio,
// multiplied by a quarter-wave-ROM NCO carrier into 8-bit signed DAC samples.
module am_modulator #(
  parameter int unsigned PHASE_W = am_mod_pkg::PHASE_W,
  parameter int unsigned LUT_AW  = am_mod_pkg::LUT_AW,
  parameter int unsigned INTERP  = am_mod_pkg::DEFAULT_INTERP,
  parameter int unsigned AUD_W   = am_mod_pkg::AUD_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [PHASE_W-1:0] phase_inc,
  input  logic [7:0]         mod_index,
  input  logic [AUD_W-1:0]   audio_in,
  input  logic               audio_valid,
  output logic               audio_ready,
  output logic [7:0]         dac_out,
  output logic               dac_valid,
  output logic               underrun
);
  import am_mod_pkg::*;

  localparam int unsigned CNT_W = (INTERP > 1) ? $clog2(INTERP) : 1;

  // Sample hold / handshake
  logic [CNT_W-1:0]        tick_cnt;
  logic                    tick;
  logic                    transfer;
  logic                    buf_full;
  logic signed [AUD_W-1:0] aud_buf;
  logic signed [AUD_W-1:0] cur_sample;
  logic [7:0]              mod_reg;

  // Envelope
  logic signed [AUD_W+8:0] aud_x_mod;
  logic signed [AUD_W:0]   scaled_r;
  logic signed [AUD_W:0]   env_r;

  // NCO and product pipeline
  logic [PHASE_W-1:0]      phase;
  logic [LUT_AW-1:0]       raw_addr;
  logic [LUT_AW-1:0]       addr_s1;
  quadrant_t               quad_s1;
  quadrant_t               quad_s2;
  logic [SINE_W-1:0]       rom_q;
  logic signed [SINE_W:0]  sine_mag;
  logic signed [SINE_W:0]  sine_s;
  logic signed [PROD_W-1:0] prod_s3;
  logic [3:0]              vld_sr;

  assign tick        = (tick_cnt == CNT_W'(INTERP - 1));
  assign audio_ready = ~buf_full & ~rst;
  assign transfer    = audio_valid & audio_ready;
  assign dac_valid   = vld_sr[3];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick_cnt <= '0;
    end else if (tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + CNT_W'(1);
    end
  end

  // A transfer can only land while the buffer is empty, so a tick seeing
  // buf_full never collides with a new write into the same slot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buf_full   <= 1'b0;
      aud_buf    <= '0;
      cur_sample <= '0;
      mod_reg    <= '0;
      underrun   <= 1'b0;
    end else begin
      if (transfer) begin
        aud_buf <= audio_in;
      end
      if (tick) begin
        mod_reg <= mod_index;
        if (buf_full) begin
          cur_sample <= aud_buf;
        end else begin
          underrun <= 1'b1;
        end
      end
      if (transfer) begin
        buf_full <= 1'b1;
      end else if (tick) begin
        buf_full <= 1'b0;
      end
    end
  end

  assign aud_x_mod = (AUD_W+9)'(cur_sample) * (AUD_W+9)'($signed({1'b0, mod_reg}));

  // Two envelope register stages line the new sample up with the sine path,
  // so it reaches dac_out four edges after the tick that loaded it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scaled_r <= '0;
      env_r    <= '0;
    end else begin
      scaled_r <= (AUD_W+1)'(aud_x_mod >>> 8);
      env_r    <= (AUD_W+1)'(ENV_ONE) + (scaled_r >>> 1);
    end
  end

  assign raw_addr = phase[PHASE_W-3 -: LUT_AW];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase   <= '0;
      addr_s1 <= '0;
      quad_s1 <= QUAD_0;
      quad_s2 <= QUAD_0;
    end else begin
      phase   <= phase + phase_inc;
      addr_s1 <= phase[PHASE_W-2] ? ~raw_addr : raw_addr;
      quad_s1 <= quadrant_t'(phase[PHASE_W-1 -: 2]);
      quad_s2 <= quad_s1;
    end
  end

  quarter_sine_rom #(
    .LUT_AW (LUT_AW),
    .SINE_W (SINE_W)
  ) u_rom (
    .clk  (clk),
    .rst  (rst),
    .addr (addr_s1),
    .data (rom_q)
  );

  always_comb begin
    sine_mag = $signed({1'b0, rom_q});
    sine_s   = sine_mag;
    if (quad_s2 == QUAD_2 || quad_s2 == QUAD_3) begin
      sine_s = -sine_mag;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prod_s3 <= '0;
      dac_out <= '0;
      vld_sr  <= '0;
    end else begin
      prod_s3 <= PROD_W'(env_r) * PROD_W'(sine_s);
      dac_out <= sat_dac(prod_s3);
      vld_sr  <= {vld_sr[2:0], 1'b1};
    end
  end

endmodule

// File: tb/tb_am_modulator.sv
// Directed bench for am_modulator: carrier tone, modulation peaks, handshake,
// tick/transfer collision, async reset and phase wrap against hand-computed values.
module tb_am_modulator;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] phase_inc;
  logic [7:0]  mod_index;
  logic [17:0] audio_in;
  logic        audio_valid;
  logic        audio_ready;
  logic [7:0]  dac_out;
  logic        dac_valid;
  logic        underrun;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int ok;

  am_modulator #(
    .PHASE_W (32),
    .LUT_AW  (8),
    .INTERP  (125),
    .AUD_W   (18)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .phase_inc   (phase_inc),
    .mod_index   (mod_index),
    .audio_in    (audio_in),
    .audio_valid (audio_valid),
    .audio_ready (audio_ready),
    .dac_out     (dac_out),
    .dac_valid   (dac_valid),
    .underrun    (underrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (cyc %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int dac_s();
    return int'($signed(dac_out));
  endfunction

  task automatic step();
    @(negedge clk);
    cyc++;
  endtask

  task automatic run_to(input int t);
    while (cyc < t) step();
  endtask

  task automatic do_reset(input logic [31:0] inc, input logic [7:0] m);
    @(negedge clk);
    rst         = 1'b1;
    audio_valid = 1'b0;
    audio_in    = '0;
    phase_inc   = inc;
    mod_index   = m;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    cyc = 0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    phase_inc   = 32'h4000_0000;
    mod_index   = 8'd0;
    audio_in    = '0;
    audio_valid = 1'b0;

    // 1: carrier only, fs/4
    @(negedge clk);
    check("rst_dac_out", dac_s(), 0);
    check("rst_dac_valid", int'(dac_valid), 0);
    check("rst_ready", int'(audio_ready), 0);
    check("rst_underrun", int'(underrun), 0);
    rst = 1'b0;
    #1;
    cyc = 0;
    check("t1_ready_after_rel", int'(audio_ready), 1);
    run_to(3);   check("t1_valid3", int'(dac_valid), 0);
    run_to(4);   check("t1_valid4", int'(dac_valid), 1);
                 check("t1_dac4", dac_s(), 0);
    run_to(5);   check("t1_dac5", dac_s(), 63);
    run_to(6);   check("t1_dac6", dac_s(), -1);
    run_to(7);   check("t1_dac7", dac_s(), -64);
    run_to(8);   check("t1_dac8", dac_s(), 0);
    run_to(124); check("t1_underrun124", int'(underrun), 0);
    run_to(125); check("t1_underrun125", int'(underrun), 1);

    // 2: full modulation peaks
    do_reset(32'h4000_0000, 8'd255);
    check("t2_ready0", int'(audio_ready), 1);
    audio_in = 18'd131071; audio_valid = 1'b1;
    step();
    audio_valid = 1'b0;
    check("t2_ready1", int'(audio_ready), 0);
    run_to(124); check("t2_ready124", int'(audio_ready), 0);
    run_to(125); check("t2_ready125", int'(audio_ready), 1);
                 check("t2_underrun125", int'(underrun), 0);
    run_to(127); check("t2_dac127", dac_s(), -64);
    run_to(128); check("t2_dac128", dac_s(), 0);
    run_to(129); check("t2_dac129_peak", dac_s(), 127);
    run_to(130); check("t2_dac130", dac_s(), -1);
    run_to(131); check("t2_dac131_trough", dac_s(), -127);
    run_to(132); check("t2_dac132", dac_s(), 0);
    audio_in = 18'(-131072); audio_valid = 1'b1;
    step();
    audio_valid = 1'b0;
    run_to(253); check("t2_dac253", dac_s(), 127);
    run_to(254); check("t2_dac254_neg", dac_s(), -1);
    run_to(255); check("t2_dac255_neg", dac_s(), -1);
    ok = 1;
    for (int k = 256; k <= 300; k++) begin
      run_to(k);
      if (!(dac_s() == 0 || dac_s() == -1)) ok = 0;
    end
    check("t2_negpeak_range", ok, 1);
    check("t2_underrun300", int'(underrun), 0);

    // 3: back-to-back handshake
    do_reset(32'h4000_0000, 8'd128);
    audio_in = 18'd65536; audio_valid = 1'b1;
    step();
    check("t3_ready1", int'(audio_ready), 0);
    audio_in = 18'(-65536);
    run_to(124); check("t3_ready124", int'(audio_ready), 0);
    run_to(125); check("t3_ready125", int'(audio_ready), 1);
    step();
    check("t3_ready126", int'(audio_ready), 0);
    audio_valid = 1'b0;
    run_to(129); check("t3_dacA129", dac_s(), 79);
    run_to(250); check("t3_underrun250", int'(underrun), 0);
    run_to(253); check("t3_dacA253", dac_s(), 79);
    run_to(254); check("t3_dacB254", dac_s(), -1);
    run_to(255); check("t3_dacB255", dac_s(), -48);

    // 4: tick and transfer on the same edge with buffer empty
    do_reset(32'h4000_0000, 8'd255);
    run_to(124); check("t4_ready124", int'(audio_ready), 1);
    audio_in = 18'd131071; audio_valid = 1'b1;
    step();
    audio_valid = 1'b0;
    check("t4_underrun125", int'(underrun), 1);
    check("t4_ready125", int'(audio_ready), 0);
    run_to(129); check("t4_dac129", dac_s(), 63);
    run_to(253); check("t4_dac253", dac_s(), 63);
    run_to(254); check("t4_dac254", dac_s(), -1);
    run_to(255); check("t4_dac255", dac_s(), -127);

    // 5: async reset mid-hold with a sample buffered
    run_to(260);
    audio_in = 18'd100000; audio_valid = 1'b1;
    step();
    audio_valid = 1'b0;
    check("t5_buffered", int'(audio_ready), 0);
    run_to(300);
    #2 rst = 1'b1;
    #1;
    check("t5_async_dac", dac_s(), 0);
    check("t5_async_valid", int'(dac_valid), 0);
    check("t5_async_ready", int'(audio_ready), 0);
    check("t5_async_underrun", int'(underrun), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    cyc = 0;
    check("t5_ready_rel", int'(audio_ready), 1);
    run_to(4);   check("t5_dac4", dac_s(), 0);
    run_to(5);   check("t5_dac5", dac_s(), 63);
    run_to(7);   check("t5_dac7", dac_s(), -64);
    run_to(125); check("t5_underrun125", int'(underrun), 1);
    run_to(129); check("t5_dac129_lost", dac_s(), 63);

    // 6: phase wrap with phase_inc = -1
    do_reset(32'hFFFF_FFFF, 8'd0);
    run_to(4); check("t6_dac4", dac_s(), 0);
    run_to(5); check("t6_dac5", dac_s(), -1);
    ok = 1;
    for (int k = 6; k <= 60; k++) begin
      run_to(k);
      if (dac_s() != -1) ok = 0;
    end
    check("t6_wrap_steady", ok, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
